// File: rtl/tensor_core_pkg.sv
// Constants and types shared by the tensor core drain-side blocks.
package tensor_core_pkg;

  // Controller bus width; results carry one extra bit of headroom.
  localparam int unsigned BUS_WIDTH    = 7;
  localparam int unsigned RESULT_WIDTH = BUS_WIDTH + 1;
  localparam int unsigned PACKED_WIDTH = 2 * RESULT_WIDTH;

  // StHalf means a low byte is held waiting for its partner.
  typedef enum logic {
    StEmpty = 1'b0,
    StHalf  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/tensor_core_result_fifo.sv
// First-word-fall-through FIFO for packed result words.
module tensor_core_result_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  // Extra pointer bit distinguishes full from empty.
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Occupancy, flags and gated head word.
  always_comb begin
    count_o = wr_ptr_q - rd_ptr_q;
    full_o  = (count_o == CntW'(Depth));
    empty_o = (count_o == '0);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
  end

  // Pointer registers; pointers wrap naturally modulo 2*Depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/tensor_core_result_packer.sv
// Packs pairs of controller results into words and queues them for the host.
module tensor_core_result_packer
  import tensor_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RESULT_WIDTH,
  parameter int unsigned WORD_WIDTH     = PACKED_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned DROP_CNT_WIDTH = 8,
  localparam int unsigned CntW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clock_in,
  input  logic                      power_on_reset_signal,
  input  logic                      result_valid,
  input  logic [DATA_WIDTH-1:0]     result_data,
  output logic                      result_ready,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [WORD_WIDTH-1:0]     out_data,
  input  logic                      out_ready,
  output logic [CntW-1:0]           fifo_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      flush_pending
);

  pack_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]     held_q, held_d;
  logic                      flush_q, flush_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic                      fifo_full, fifo_empty;
  logic                      push;
  logic [WORD_WIDTH-1:0]     push_data;
  logic                      flush_req, accept;

  // Handshake: only a held byte with nowhere to go blocks input.
  always_comb begin
    result_ready  = !(state_q == StHalf && fifo_full);
    accept        = result_valid && result_ready;
    flush_req     = flush || flush_q;
    out_valid     = !fifo_empty;
    drop_count    = drop_q;
    flush_pending = flush_q;
  end

  // Packer state register.
  always_ff @(posedge clock_in or posedge power_on_reset_signal) begin
    if (power_on_reset_signal) state_q <= StEmpty;
    else                       state_q <= state_d;
  end

  // Packer next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept && !flush_req) state_d = StHalf;
      StHalf:  if (accept || (flush_req && !fifo_full)) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Packer outputs: FIFO push, held byte and flush request updates.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    held_d    = held_q;
    flush_d   = flush_req;
    unique case (state_q)
      StEmpty: begin
        // A request seen while empty is always retired here.
        flush_d = 1'b0;
        if (accept) begin
          if (flush_req) begin
            push      = 1'b1;
            push_data = WORD_WIDTH'(result_data);
          end else begin
            held_d = result_data;
          end
        end
      end
      StHalf: begin
        if (accept) begin
          // The pair completes the word, so a pending flush has nothing to pad.
          push      = 1'b1;
          push_data = {result_data, held_q};
          flush_d   = 1'b0;
        end else if (flush_req && !fifo_full) begin
          push      = 1'b1;
          push_data = WORD_WIDTH'(held_q);
          flush_d   = 1'b0;
        end
      end
      default: flush_d = 1'b0;
    endcase
  end

  // Held byte, sticky flush request and saturating drop counter.
  always_ff @(posedge clock_in or posedge power_on_reset_signal) begin
    if (power_on_reset_signal) begin
      held_q  <= '0;
      flush_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      held_q  <= held_d;
      flush_q <= flush_d;
      if (result_valid && !result_ready && drop_q != '1) begin
        drop_q <= drop_q + DROP_CNT_WIDTH'(1);
      end
    end
  end

  tensor_core_result_fifo #(
    .Width (WORD_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock_in),
    .rst_i       (power_on_reset_signal),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (out_ready),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (out_data),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_tensor_core_result_packer.sv
// Bench for the result packer: directed checks plus a scoreboard model.
module tb_tensor_core_result_packer;

  logic        clock_in = 1'b0;
  logic        power_on_reset_signal = 1'b1;
  logic        result_valid = 1'b0;
  logic [7:0]  result_data = '0;
  logic        result_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_count;
  logic        flush_pending;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard model state.
  logic [15:0] m_q[$];
  logic        m_half = 1'b0;
  logic [7:0]  m_held = '0;
  logic        m_flush = 1'b0;
  logic [7:0]  m_drop = '0;

  tensor_core_result_packer dut (
    .clock_in              (clock_in),
    .power_on_reset_signal (power_on_reset_signal),
    .result_valid          (result_valid),
    .result_data           (result_data),
    .result_ready          (result_ready),
    .flush                 (flush),
    .out_valid             (out_valid),
    .out_data              (out_data),
    .out_ready             (out_ready),
    .fifo_count            (fifo_count),
    .drop_count            (drop_count),
    .flush_pending         (flush_pending)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle: compare DUT against the model, then advance the model to the next edge.
  always @(negedge clock_in) begin
    logic        full, ready, freq, acc, do_push;
    logic [15:0] w;
    if (power_on_reset_signal) begin
      m_q.delete();
      m_half = 1'b0; m_held = '0; m_flush = 1'b0; m_drop = '0;
    end
    check("sb_ready", result_ready, !(m_half && m_q.size() == 8));
    check("sb_valid", out_valid, m_q.size() != 0);
    check("sb_count", fifo_count, m_q.size());
    check("sb_drop", drop_count, m_drop);
    check("sb_fpend", flush_pending, m_flush);
    if (!power_on_reset_signal) begin
      full    = (m_q.size() == 8);
      ready   = !(m_half && full);
      freq    = flush || m_flush;
      acc     = result_valid && ready;
      do_push = 1'b0;
      w       = '0;
      if (result_valid && !ready && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      if (!m_half) begin
        if (acc) begin
          if (freq) begin do_push = 1'b1; w = {8'h00, result_data}; end
          else begin m_held = result_data; m_half = 1'b1; end
        end
        m_flush = 1'b0;
      end else if (acc) begin
        do_push = 1'b1; w = {result_data, m_held}; m_half = 1'b0; m_flush = 1'b0;
      end else if (freq && !full) begin
        do_push = 1'b1; w = {8'h00, m_held}; m_half = 1'b0; m_flush = 1'b0;
      end else begin
        m_flush = freq;
      end
      if (m_q.size() != 0 && out_ready) begin
        check("sb_pop_word", out_data, m_q[0]);
        void'(m_q.pop_front());
      end
      if (do_push) m_q.push_back(w);
    end
  end

  // All tasks below start and end at posedge+2.
  task automatic step(input int n);
    repeat (n) begin @(posedge clock_in); #2; end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic f);
    result_valid = v; result_data = b; flush = f;
    step(1);
    result_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    out_ready = 1'b1;
    while (fifo_count != 0 && budget < 50) begin step(1); budget++; end
    check("drain_done", fifo_count, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] drop_before;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", result_ready, 1);
    @(posedge clock_in); #2;
    power_on_reset_signal = 1'b0;
    step(1);

    // Basic pair with a signed second result.
    drive(1'b1, 8'd5, 1'b0);
    drive(1'b1, 8'hFD, 1'b0);
    check("pair_valid", out_valid, 1);
    check("pair_word", out_data, 16'hFD05);
    check("pair_count", fifo_count, 1);
    drain();

    // Fill, hold one, drop one, then drain in order.
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0);
    check("fill_count", fifo_count, 8);
    check("fill_ready", result_ready, 1);
    drive(1'b1, 8'd17, 1'b0);
    check("held_ready", result_ready, 0);
    drive(1'b1, 8'd18, 1'b0);
    check("drop_cnt", drop_count, 1);
    check("drop_ready", result_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_word", out_data, {8'(2 * k + 2), 8'(2 * k + 1)});
      step(1);
    end
    out_ready = 1'b0;
    check("drained", fifo_count, 0);
    drive(1'b0, 8'h00, 1'b1);
    check("flush17", out_data, 16'h0011);
    drain();

    // Flush of a single held result, then flush while empty.
    drive(1'b1, 8'h7F, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    check("flush7f", out_data, 16'h007F);
    check("flush7f_cnt", fifo_count, 1);
    drain();
    drive(1'b0, 8'h00, 1'b1);
    step(1);
    check("flush_empty", fifo_count, 0);
    check("flush_empty_p", flush_pending, 0);

    // Flush blocked by a full FIFO until one word leaves.
    for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    check("fp_set", flush_pending, 1);
    step(2);
    check("fp_hold", flush_pending, 1);
    check("fp_full", fifo_count, 8);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("fp_popped", fifo_count, 7);
    step(1);
    check("fp_clear", flush_pending, 0);
    check("fp_pushed", fifo_count, 8);
    drain();

    // Same-cycle result and flush while empty.
    drive(1'b1, 8'h80, 1'b1);
    check("same_word", out_data, 16'h0080);
    check("same_cnt", fifo_count, 1);
    step(1);
    check("same_only", fifo_count, 1);
    drain();

    // Streaming with a toggling host.
    drop_before = drop_count;
    for (int i = 0; i < 200; i++) begin
      result_valid = 1'b1;
      result_data  = 8'($urandom);
      out_ready    = i[0];
      step(1);
    end
    result_valid = 1'b0;
    check("stream_drops", drop_count, drop_before);
    drain();

    // Reset in the middle of a burst.
    for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
    result_valid = 1'b1; result_data = 8'h55;
    power_on_reset_signal = 1'b1;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_count", fifo_count, 0);
    check("mrst_drop", drop_count, 0);
    check("mrst_data", out_data, 0);
    check("mrst_fp", flush_pending, 0);
    result_valid = 1'b0;
    step(1);
    power_on_reset_signal = 1'b0;
    step(3);
    check("post_valid", out_valid, 0);
    drive(1'b0, 8'h00, 1'b1);
    check("post_flush", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
